stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl_pkg.sv | 33 +++
 rtl/stall_ctrl_md_counter.sv | 43 ++++
 rtl/stall_ctrl.sv | 127 ++++++++++++
 tb/tb_stall_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stall_ctrl_pkg
// Shared widths, constants and types for the stall controller.
//   TW          : Tnew/Tuse width
//   AW          : register-address width
//   CNT_W       : mult/div countdown width
//   MULT_CYCLES : busy cycles loaded for a multiply
//   DIV_CYCLES  : busy cycles loaded for a divide
//   stage_t     : one scoreboard entry (destination, write enable, Tnew)
//   STAGE_BUBBLE: empty scoreboard entry
// -----------------------------------------------------------------------------
package stall_ctrl_pkg;

  localparam int TW          = 2;
  localparam int AW          = 5;
  localparam int CNT_W       = 4;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  typedef struct packed {
    logic [AW-1:0] a3;
    logic          w;
    logic [TW-1:0] tnew;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{a3: '0, w: 1'b0, tnew: '0};

  // Remaining latency after one more stage; saturates at zero.
  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/stall_ctrl_md_counter.sv
// -----------------------------------------------------------------------------
// md_counter
// Countdown of the remaining mult/div busy cycles.
//   clk_i     : rising-edge clock
//   reset_n_i : synchronous active-low reset (clears the count)
//   start_i   : E issues a mult/div this cycle (reloads, even when busy)
//   div_i     : 1 = divide, 0 = multiply
//   cnt_o     : remaining busy cycles
//   busy_o    : count is nonzero
// -----------------------------------------------------------------------------
module md_counter
  import stall_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             div_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      // A new operation always wins over one still in flight.
      cnt_d = div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
// Destination scoreboard for E/M/W plus Tnew/Tuse hazard detection and the
// mult/div busy interlock of a 5-stage pipeline.
//   clk, reset_n              : clock, synchronous active-low reset
//   D_A1/D_A2, D_use_rs/rt    : D-stage source addresses and read flags
//   D_Tuse_rs/rt              : cycles until D needs each operand
//   D_A3, D_W, D_Tnew         : D-stage destination, write enable, latency
//   D_md, E_md_start, E_md_div: mult/div interlock inputs
//   A3_E/M/W, E_W/M_W/W_W     : scoreboard to the forward unit
//   Tnew_E, Tnew_M            : remaining latency in E and M
//   stall                     : freeze PC and F/D, bubble into D/E
//   md_busy, md_cnt           : mult/div unit state
// Build option: define STALL_CTRL_MD_EN to enable the mult/div counter and
// md hazard; otherwise md_cnt/md_busy read 0 and the md inputs are ignored.
// -----------------------------------------------------------------------------
module stall_ctrl
  import stall_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    D_A1,
  input  logic [AW-1:0]    D_A2,
  input  logic             D_use_rs,
  input  logic             D_use_rt,
  input  logic [TW-1:0]    D_Tuse_rs,
  input  logic [TW-1:0]    D_Tuse_rt,
  input  logic [AW-1:0]    D_A3,
  input  logic             D_W,
  input  logic [TW-1:0]    D_Tnew,
  input  logic             D_md,
  input  logic             E_md_start,
  input  logic             E_md_div,
  output logic [AW-1:0]    A3_E,
  output logic [AW-1:0]    A3_M,
  output logic [AW-1:0]    A3_W,
  output logic             E_W,
  output logic             M_W,
  output logic             W_W,
  output logic [TW-1:0]    Tnew_E,
  output logic [TW-1:0]    Tnew_M,
  output logic             stall,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
);

  stage_t        e_q, e_d;
  stage_t        m_q, m_d;
  logic [AW-1:0] w_a3_q, w_a3_d;
  logic          w_w_q, w_w_d;
  logic          rs_hz, rt_hz, md_hz;

  // W is never a stall source (forwarding covers it), so only E and M count.
  function automatic logic src_hazard(input logic [AW-1:0] addr,
                                      input logic          use_src,
                                      input logic [TW-1:0] tuse,
                                      input stage_t        e,
                                      input stage_t        m);
    return use_src && (addr != '0) &&
           (((addr == e.a3) && e.w && (e.tnew > tuse)) ||
            ((addr == m.a3) && m.w && (m.tnew > tuse)));
  endfunction

`ifdef STALL_CTRL_MD_EN
  md_counter u_md_counter (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .start_i   (E_md_start),
    .div_i     (E_md_div),
    .cnt_o     (md_cnt),
    .busy_o    (md_busy)
  );

  assign md_hz = D_md && (md_busy || E_md_start);
`else
  logic md_in_unused;

  assign md_in_unused = ^{D_md, E_md_start, E_md_div};
  assign md_cnt       = '0;
  assign md_busy      = 1'b0;
  assign md_hz        = 1'b0;
`endif

  assign rs_hz = src_hazard(D_A1, D_use_rs, D_Tuse_rs, e_q, m_q);
  assign rt_hz = src_hazard(D_A2, D_use_rt, D_Tuse_rt, e_q, m_q);
  assign stall = rs_hz | rt_hz | md_hz;

  always_comb begin
    e_d = STAGE_BUBBLE;
    if (!stall) begin
      e_d.a3   = D_A3;
      // A write to $0 is discarded, so it must never look like a producer.
      e_d.w    = D_W && (D_A3 != '0);
      e_d.tnew = D_Tnew;
    end
    // M and W advance every cycle; only D/E is held back by stall.
    m_d.a3   = e_q.a3;
    m_d.w    = e_q.w;
    m_d.tnew = tnew_dec(e_q.tnew);
    w_a3_d   = m_q.a3;
    w_w_d    = m_q.w;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_q    <= STAGE_BUBBLE;
      m_q    <= STAGE_BUBBLE;
      w_a3_q <= '0;
      w_w_q  <= 1'b0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_a3_q <= w_a3_d;
      w_w_q  <= w_w_d;
    end
  end

  assign A3_E   = e_q.a3;
  assign E_W    = e_q.w;
  assign Tnew_E = e_q.tnew;
  assign A3_M   = m_q.a3;
  assign M_W    = m_q.w;
  assign Tnew_M = m_q.tnew;
  assign A3_W   = w_a3_q;
  assign W_W    = w_w_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl
// Directed stimulus for stall_ctrl. Each driven cycle pushes its hand-derived
// expected outputs into a scoreboard queue; a monitor on the falling edge pops
// and compares against the DUT. Expectations for the mult/div section follow
// the STALL_CTRL_MD_EN build option.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

`ifdef STALL_CTRL_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [4:0] D_A1, D_A2, D_A3;
  logic       D_use_rs, D_use_rt, D_W;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic       D_md, E_md_start, E_md_div;
  logic [4:0] A3_E, A3_M, A3_W;
  logic       E_W, M_W, W_W;
  logic [1:0] Tnew_E, Tnew_M;
  logic       stall, md_busy;
  logic [3:0] md_cnt;

  stall_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .D_A1       (D_A1),
    .D_A2       (D_A2),
    .D_use_rs   (D_use_rs),
    .D_use_rt   (D_use_rt),
    .D_Tuse_rs  (D_Tuse_rs),
    .D_Tuse_rt  (D_Tuse_rt),
    .D_A3       (D_A3),
    .D_W        (D_W),
    .D_Tnew     (D_Tnew),
    .D_md       (D_md),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .A3_E       (A3_E),
    .A3_M       (A3_M),
    .A3_W       (A3_W),
    .E_W        (E_W),
    .M_W        (M_W),
    .W_W        (W_W),
    .Tnew_E     (Tnew_E),
    .Tnew_M     (Tnew_M),
    .stall      (stall),
    .md_busy    (md_busy),
    .md_cnt     (md_cnt)
  );

  typedef struct {
    string       name;
    logic [27:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // {stall, md_busy, md_cnt, Tnew_E, Tnew_M, E_W, M_W, W_W, A3_E, A3_M, A3_W}
  logic [27:0] act;
  assign act = {stall, md_busy, md_cnt, Tnew_E, Tnew_M, E_W, M_W, W_W,
                A3_E, A3_M, A3_W};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_set(input logic [4:0] a1, input logic urs, input logic [1:0] trs,
                       input logic [4:0] a2, input logic urt, input logic [1:0] trt,
                       input logic [4:0] a3, input logic w, input logic [1:0] tn);
    D_A1 = a1; D_use_rs = urs; D_Tuse_rs = trs;
    D_A2 = a2; D_use_rt = urt; D_Tuse_rt = trt;
    D_A3 = a3; D_W = w; D_Tnew = tn;
  endtask

  task automatic md_set(input logic md, input logic start, input logic dv);
    D_md = md; E_md_start = start; E_md_div = dv;
  endtask

  task automatic exp_push(input string name, input logic st,
                          input logic [4:0] a3e, input logic ew, input logic [1:0] te,
                          input logic [4:0] a3m, input logic mw, input logic [1:0] tm,
                          input logic [4:0] a3w, input logic ww,
                          input logic [3:0] cnt, input logic busy);
    exp_t e;
    e.name = name;
    e.v    = {st, busy, cnt, te, tm, ew, mw, ww, a3e, a3m, a3w};
    sb.push_back(e);
  endtask

  // Monitor: compare whatever the current cycle's expectation is.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h required %h (stall,busy,cnt,TnE,TnM,EW,MW,WW,A3E,A3M,A3W)",
                 e.name, act, e.v);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    d_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    md_set(0, 0, 0);
    tick();
    tick();
    reset_n = 1'b1;

    // lw $8 in D (Tnew 2) right after reset
    d_set(29, 1, 1, 0, 0, 0, 8, 1, 2);
    exp_push("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // addu $10 uses $8 with Tuse 0: two stall cycles
    d_set(8, 1, 0, 0, 0, 0, 10, 1, 1);
    exp_push("loaduse_e", 1, 8, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    exp_push("loaduse_m", 1, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0);
    tick();
    exp_push("loaduse_done", 0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0);
    tick();
    // beq uses $10 (addu in E, Tnew 1): one stall cycle
    d_set(10, 1, 0, 0, 0, 0, 0, 0, 0);
    exp_push("aluuse_e", 1, 10, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    exp_push("aluuse_done", 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0);
    tick();
    // addu $11, then a rt reader of $11 with Tuse 1 that also writes $0
    d_set(0, 0, 0, 0, 0, 0, 11, 1, 1);
    exp_push("addu11", 0, 0, 0, 0, 0, 0, 0, 10, 1, 0, 0);
    tick();
    d_set(0, 0, 0, 11, 1, 1, 0, 1, 2);
    exp_push("tuse1_nostall", 0, 11, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // $0 writer in E with Tnew 2; D reads $0
    d_set(0, 1, 0, 0, 0, 0, 0, 0, 0);
    exp_push("zero_reg", 0, 0, 0, 2, 11, 1, 0, 0, 0, 0, 0);
    tick();
    d_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_push("zero_wr_decr", 0, 0, 0, 0, 0, 0, 1, 11, 1, 0, 0);
    tick();
    exp_push("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // div start with mflo in D, then 10 busy cycles
    md_set(1, 1, 1);
    exp_push("div_start", MD_EN, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 10; k >= 1; k--) begin
      md_set(1, 0, 0);
      exp_push($sformatf("div_busy_%0d", k), MD_EN, 0, 0, 0, 0, 0, 0, 0, 0,
               MD_EN ? 4'(k) : 4'd0, MD_EN);
      tick();
    end
    exp_push("div_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // mult, restarted at count 3, then a div taking over mid-mult
    md_set(0, 1, 0);
    exp_push("mult_start", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    md_set(0, 0, 0);
    exp_push("mult_5", 0, 0, 0, 0, 0, 0, 0, 0, 0, MD_EN ? 4'd5 : 4'd0, MD_EN);
    tick();
    exp_push("mult_4", 0, 0, 0, 0, 0, 0, 0, 0, 0, MD_EN ? 4'd4 : 4'd0, MD_EN);
    tick();
    md_set(0, 1, 0);
    exp_push("mult_at3", 0, 0, 0, 0, 0, 0, 0, 0, 0, MD_EN ? 4'd3 : 4'd0, MD_EN);
    tick();
    md_set(0, 1, 1);
    exp_push("mult_reload", 0, 0, 0, 0, 0, 0, 0, 0, 0, MD_EN ? 4'd5 : 4'd0, MD_EN);
    tick();
    md_set(0, 0, 0);
    exp_push("div_10", 0, 0, 0, 0, 0, 0, 0, 0, 0, MD_EN ? 4'd10 : 4'd0, MD_EN);
    tick();
    exp_push("div_9", 0, 0, 0, 0, 0, 0, 0, 0, 0, MD_EN ? 4'd9 : 4'd0, MD_EN);
    tick();
    d_set(0, 0, 0, 0, 0, 0, 5, 1, 1);
    exp_push("div_8", 0, 0, 0, 0, 0, 0, 0, 0, 0, MD_EN ? 4'd8 : 4'd0, MD_EN);
    tick();
    // reset with count 7 and a live writer in E
    d_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    exp_push("pre_reset", 0, 5, 1, 1, 0, 0, 0, 0, 0, MD_EN ? 4'd7 : 4'd0, MD_EN);
    tick();
    reset_n = 1'b1;
    md_set(1, 0, 0);
    d_set(5, 1, 0, 0, 0, 0, 0, 0, 0);
    exp_push("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    md_set(0, 0, 0);
    d_set(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
